qam_symbol_mapper: RTL and testbench

Parametrised successor to the fixed 16-QAM baseband mapper. Accumulates a serial bit stream into symbols of run-time selectable order (QPSK/16-QAM/64-QAM) and Gray-maps each symbol to signed odd-integer I/Q levels. Mapped symbols are buffered in an output FIFO with a valid/ready handshake. Sits in the data_clk domain between the serial data input and the IQ CDC FIFO.

---
 rtl/qam_pkg.sv | 39 +++
 rtl/qam_symbol_mapper_if.sv | 19 +
 rtl/qam_sym_fifo.sv | 65 ++++++
 rtl/qam_symbol_mapper.sv | 168 ++++++++++++++++
 tb/tb_qam_symbol_mapper.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
// Shared definitions for the QAM symbol mapper and its helpers:
//   - qam_mode_e      : modulation-order encodings (11 is reserved, mapped as QPSK)
//   - bits_per_symbol : number of serial bits that make one symbol for a mode
//   - gray_to_level   : Gray-coded axis field -> signed odd-integer level
// ---------------------------------------------------------------------------
package qam_pkg;

    typedef enum logic [1:0] {
        MODE_QPSK  = 2'b00,
        MODE_16QAM = 2'b01,
        MODE_64QAM = 2'b10,
        MODE_RSVD  = 2'b11
    } qam_mode_e;

    // Bits per symbol: 2 / 4 / 6; the reserved code behaves like QPSK.
    function automatic logic [2:0] bits_per_symbol(input qam_mode_e mode);
        case (mode)
            MODE_16QAM: return 3'd4;
            MODE_64QAM: return 3'd6;
            default:    return 3'd2;
        endcase
    endfunction

    // Converts a Gray field of axis_bits (1..3) bits, right-aligned in gray,
    // to the level 2n - (2^b - 1). Unused upper Gray bits must be zero, which
    // lets one xor-cascade serve all three widths. Every level lies in -7..+7,
    // so the 4-bit wrap-around subtraction is exact as a signed result.
    function automatic logic signed [3:0] gray_to_level(input logic [2:0] gray,
                                                        input logic [1:0] axis_bits);
        logic [3:0] bin;
        logic [3:0] offset;
        bin    = {1'b0, gray ^ (gray >> 1) ^ (gray >> 2)};
        offset = (4'd1 << axis_bits) - 4'd1;
        return $signed((bin << 1) - offset);
    endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// ---------------------------------------------------------------------------
// qam_symbol_mapper_if
// Mapped-symbol output stream (valid/ready).
//   I_data, Q_data : signed levels of the current head symbol
//   out_valid      : head symbol present
//   out_ready      : consumer takes the head when out_valid && out_ready
// master = mapper side, slave = consumer side.
// ---------------------------------------------------------------------------
interface qam_symbol_mapper_if #(
    parameter int LVL_W = 4
);
    logic signed [LVL_W-1:0] I_data;
    logic signed [LVL_W-1:0] Q_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output I_data, output Q_data, output out_valid, input out_ready);
    modport slave  (input  I_data, input  Q_data, input  out_valid, output out_ready);
endinterface

// File: rtl/qam_sym_fifo.sv
// ---------------------------------------------------------------------------
// qam_sym_fifo
// Synchronous show-ahead FIFO: head_data always presents the oldest entry.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data
//   pop               : remove the head (ignored when empty)
//   head_data         : oldest entry, zero while empty
//   full, empty       : occupancy flags
// A push while full succeeds only if a pop happens in the same cycle.
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module qam_sym_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Gating the head with empty keeps the output at zero after reset without
    // having to clear the storage array.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qam_symbol_mapper.sv
// ---------------------------------------------------------------------------
// qam_symbol_mapper
// Collects a serial bit stream into QPSK / 16-QAM / 64-QAM symbols, Gray-maps
// each symbol to signed odd-integer I/Q levels and queues the result in a
// show-ahead FIFO with a valid/ready output.
// Ports:
//   clk, rst_n         : data clock, asynchronous active-low reset
//   enable             : mapping enable; low discards any partial symbol
//   mode               : 00 QPSK, 01 16-QAM, 10 64-QAM, 11 treated as QPSK
//   data_in/data_valid : serial bit, first bit of a symbol is its MSB
//   iq (master)        : I_data, Q_data, out_valid, out_ready
//   overflow, ovf_clr  : sticky dropped-symbol flag and its clear
//   sym_count          : wrapping count of pushed symbols (SYMBOL_COUNT_EN)
// Build option: define SYMBOL_COUNT_EN to add the sym_count port and counter.
// LVL_W must be >= 4 so that the 64-QAM levels of +/-7 fit.
// ---------------------------------------------------------------------------
module qam_symbol_mapper
    import qam_pkg::*;
#(
    parameter int LVL_W = 4,
    parameter int DEPTH = 4
`ifdef SYMBOL_COUNT_EN
   ,parameter int CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                data_in,
    input  logic                data_valid,
    input  logic                ovf_clr,
    output logic                overflow,
`ifdef SYMBOL_COUNT_EN
    output logic [CNT_W-1:0]    sym_count,
`endif
    qam_symbol_mapper_if.master iq
);

    logic [2:0]              bit_cnt;
    logic [4:0]              shift_reg;
    qam_mode_e               cur_mode;
    qam_mode_e               eff_mode;
    logic [5:0]              shift_next;
    logic [2:0]              sym_bits;
    logic                    bit_accept;
    logic                    sym_done;
    logic [2:0]              i_gray;
    logic [2:0]              q_gray;
    logic [1:0]              axis_bits;
    logic signed [3:0]       i_lvl4;
    logic signed [3:0]       q_lvl4;
    logic [2*LVL_W-1:0]      push_data;
    logic [2*LVL_W-1:0]      head_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    sym_drop;

    assign bit_accept = enable && data_valid;

    // The first bit of a symbol sees the live mode input; later bits use the
    // latched copy, so a mid-symbol mode change only affects the next symbol.
    assign eff_mode   = (bit_cnt == 3'd0) ? qam_mode_e'(mode) : cur_mode;
    assign sym_bits   = bits_per_symbol(eff_mode);
    assign shift_next = {shift_reg, data_in};
    assign sym_done   = bit_accept && (bit_cnt == sym_bits - 3'd1);

    // Bit collection. Only the previous five bits are stored; the completing
    // bit is used straight from data_in through shift_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 5'd0;
            cur_mode  <= MODE_QPSK;
        end else if (!enable) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 5'd0;
        end else if (data_valid) begin
            if (bit_cnt == 3'd0) begin
                cur_mode <= qam_mode_e'(mode);
            end
            if (sym_done) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 5'd0;
            end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= shift_next[4:0];
            end
        end
    end

    // Split the completed symbol (right-aligned in shift_next) into its
    // I (upper half) and Q (lower half) Gray fields.
    always_comb begin
        i_gray    = {2'b00, shift_next[1]};
        q_gray    = {2'b00, shift_next[0]};
        axis_bits = 2'd1;
        case (eff_mode)
            MODE_16QAM: begin
                i_gray    = {1'b0, shift_next[3:2]};
                q_gray    = {1'b0, shift_next[1:0]};
                axis_bits = 2'd2;
            end
            MODE_64QAM: begin
                i_gray    = shift_next[5:3];
                q_gray    = shift_next[2:0];
                axis_bits = 2'd3;
            end
            default: begin
                i_gray    = {2'b00, shift_next[1]};
                q_gray    = {2'b00, shift_next[0]};
                axis_bits = 2'd1;
            end
        endcase
    end

    assign i_lvl4    = gray_to_level(i_gray, axis_bits);
    assign q_lvl4    = gray_to_level(q_gray, axis_bits);
    assign push_data = {LVL_W'(i_lvl4), LVL_W'(q_lvl4)};

    assign fifo_pop  = iq.out_ready && !fifo_empty;
    assign sym_drop  = sym_done && fifo_full && !fifo_pop;

    qam_sym_fifo #(
        .WIDTH (2*LVL_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sym_done),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign iq.out_valid = !fifo_empty;
    assign iq.I_data    = head_data[2*LVL_W-1:LVL_W];
    assign iq.Q_data    = head_data[LVL_W-1:0];

    // A new drop wins over a simultaneous clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (sym_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef SYMBOL_COUNT_EN
    logic push_ok;

    assign push_ok = sym_done && (!fifo_full || fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count <= '0;
        end else if (push_ok) begin
            sym_count <= sym_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// ---------------------------------------------------------------------------
// tb_qam_symbol_mapper
// Directed bench for qam_symbol_mapper: a table of single-symbol vectors plus
// hand-written sequences for mode switching, overflow, full push+pop,
// enable drop and asynchronous reset. Inputs change on the falling edge,
// outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_qam_symbol_mapper;

    localparam int LVL_W = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] mode;
        logic [5:0] bits;
        int         k;
        int         exp_i;
        int         exp_q;
    } vec_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       enable     = 1'b0;
    logic [1:0] mode       = 2'b00;
    logic       data_in    = 1'b0;
    logic       data_valid = 1'b0;
    logic       ovf_clr    = 1'b0;
    logic       overflow;
`ifdef SYMBOL_COUNT_EN
    logic [15:0] sym_count;
`endif

    int   checks    = 0;
    int   errors    = 0;
    int   exp_count = 0;
    vec_t vecs [9];

    qam_symbol_mapper_if #(.LVL_W(LVL_W)) iq ();

    qam_symbol_mapper #(
        .LVL_W (LVL_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
`ifdef SYMBOL_COUNT_EN
        .sym_count  (sym_count),
`endif
        .iq         (iq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one accepted bit on the next falling edge.
    task automatic apply_stimulus(input logic [1:0] m, input logic b);
        @(negedge clk);
        enable     = 1'b1;
        mode       = m;
        data_in    = b;
        data_valid = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Send k bits MSB-first; returns one cycle after the last bit was taken.
    task automatic send_symbol(input logic [1:0] m, input logic [5:0] bits, input int k);
        for (int i = k - 1; i >= 0; i--) begin
            apply_stimulus(m, bits[i]);
        end
        idle_cycle();
    endtask

    task automatic check_head(input string tag, input int ei, input int eq);
        check_output({tag, " valid"}, iq.out_valid, 1);
        check_output({tag, " I"}, iq.I_data, ei);
        check_output({tag, " Q"}, iq.Q_data, eq);
    endtask

    // Pop four entries with out_ready held high and confirm order and empty.
    task automatic drain_check(input string tag, input int ei[4], input int eq[4]);
        iq.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_head($sformatf("%s pop%0d", tag, j), ei[j], eq[j]);
            @(negedge clk);
        end
        check_output({tag, " empty"}, iq.out_valid, 0);
        iq.out_ready = 1'b0;
    endtask

    task automatic check_count(input string tag);
`ifdef SYMBOL_COUNT_EN
        check_output({tag, " sym_count"}, sym_count, exp_count);
`else
        checks = checks + 0;
`endif
    endtask

    initial begin
        vecs[0] = '{2'b01, 6'b001011, 4,  3,  1};
        vecs[1] = '{2'b10, 6'b000100, 6, -7,  7};
        vecs[2] = '{2'b00, 6'b000010, 2,  1, -1};
        vecs[3] = '{2'b01, 6'b000001, 4, -3, -1};
        vecs[4] = '{2'b10, 6'b011010, 6, -3, -1};
        vecs[5] = '{2'b10, 6'b110111, 6,  1,  3};
        vecs[6] = '{2'b10, 6'b101001, 6,  5, -5};
        vecs[7] = '{2'b11, 6'b000001, 2, -1,  1};
        vecs[8] = '{2'b00, 6'b000011, 2,  1,  1};

        iq.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset valid", iq.out_valid, 0);
        check_output("reset I", iq.I_data, 0);
        check_output("reset Q", iq.Q_data, 0);
        check_output("reset overflow", overflow, 0);
        check_count("reset");
        rst_n = 1'b1;

        $display("[TB] single-symbol vectors");
        iq.out_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            send_symbol(vecs[v].mode, vecs[v].bits, vecs[v].k);
            exp_count++;
            check_head($sformatf("vec%0d", v), vecs[v].exp_i, vecs[v].exp_q);
            @(negedge clk);
            check_output($sformatf("vec%0d one-cycle", v), iq.out_valid, 0);
        end

        $display("[TB] mode change mid-symbol");
        apply_stimulus(2'b01, 1'b1);
        apply_stimulus(2'b01, 1'b0);
        apply_stimulus(2'b10, 1'b1);
        apply_stimulus(2'b10, 1'b1);
        idle_cycle();
        exp_count++;
        check_head("switch 16qam", 3, 1);
        send_symbol(2'b10, 6'b000100, 6);
        exp_count++;
        check_head("switch 64qam", -7, 7);
        @(negedge clk);

        $display("[TB] overflow");
        iq.out_ready = 1'b0;
        send_symbol(2'b00, 6'b00, 2);
        send_symbol(2'b00, 6'b01, 2);
        send_symbol(2'b00, 6'b10, 2);
        send_symbol(2'b00, 6'b11, 2);
        send_symbol(2'b00, 6'b00, 2);
        exp_count += 4;
        check_output("ovf set", overflow, 1);
        check_count("ovf");
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_output("ovf cleared", overflow, 0);
        drain_check("ovf", '{-1, -1, 1, 1}, '{-1, 1, -1, 1});

        $display("[TB] full with push and pop together");
        send_symbol(2'b00, 6'b00, 2);
        send_symbol(2'b00, 6'b01, 2);
        send_symbol(2'b00, 6'b10, 2);
        send_symbol(2'b00, 6'b11, 2);
        apply_stimulus(2'b00, 1'b1);
        apply_stimulus(2'b00, 1'b0);
        iq.out_ready = 1'b1;
        idle_cycle();
        iq.out_ready = 1'b0;
        exp_count += 5;
        check_output("pushpop no ovf", overflow, 0);
        drain_check("pushpop", '{-1, 1, 1, 1}, '{1, -1, 1, -1});

        $display("[TB] enable drop mid-symbol");
        iq.out_ready = 1'b1;
        apply_stimulus(2'b10, 1'b1);
        apply_stimulus(2'b10, 1'b1);
        apply_stimulus(2'b10, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        check_output("enable partial", iq.out_valid, 0);
        send_symbol(2'b10, 6'b000100, 6);
        exp_count++;
        check_head("enable resume", -7, 7);
        check_count("enable");
        @(negedge clk);

        $display("[TB] asynchronous reset mid-symbol");
        iq.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            send_symbol(2'b00, 6'b11, 2);
        end
        check_output("pre-reset ovf", overflow, 1);
        apply_stimulus(2'b01, 1'b1);
        #2;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        #1;
        check_output("async valid", iq.out_valid, 0);
        check_output("async I", iq.I_data, 0);
        check_output("async Q", iq.Q_data, 0);
        check_output("async overflow", overflow, 0);
        exp_count = 0;
        check_count("async");
        @(negedge clk);
        rst_n        = 1'b1;
        iq.out_ready = 1'b1;
        send_symbol(2'b01, 6'b001011, 4);
        exp_count++;
        check_head("post-reset", 3, 1);
        check_count("post-reset");
        @(negedge clk);

        $display("[TB] model symbol count at end: %0d", exp_count);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
